// File: rtl/exp_row_align.sv
// -----------------------------------------------------------------------------
// exp_row_align
//
// Two-stage exponent alignment pipeline for one row of a block floating-point
// cross product.
//
// Stage 1 captures the raw exponents of a row and its maximum non-zero exponent.
// Stage 2 turns that into per-element right-shift amounts, a zero-exponent mask
// and a row index within the current tile.
//
// Both stages use valid/ready handshaking. A stage may load while its current
// row leaves in the same cycle, so throughput is one row per clock.
//
// Parameters
//   ROW_LEN  : exponents per row
//   FP_EXP_W : raw exponent width
//   SHIFT_W  : shift width; shifts saturate at 2^SHIFT_W-1
//
// Ports
//   clk           : clock; all state updates on the rising edge
//   rstn          : synchronous active-low reset
//   in_valid      : input row valid
//   in_ready      : block accepts an input row this cycle
//   in_exp        : raw exponents; element k at [(k+1)*FP_EXP_W-1 -: FP_EXP_W]
//   in_last       : last row of a tile
//   out_valid     : output row valid
//   out_ready     : downstream accepts the output row
//   out_max_exp   : row maximum raw exponent (0 for an all-zero row)
//   out_shift     : per-element right-shift amounts, packed like in_exp
//   out_zero_mask : bit k set when element k has raw exponent 0
//   out_last      : in_last carried with its row
//   out_row_idx   : row index within the current tile; wraps 255 -> 0
//   sat_cnt       : only with EXP_ALIGN_STATS_EN. Saturating count of non-zero
//                   elements whose shift was clamped.
//
// Configuration macro: EXP_ALIGN_STATS_EN enables the sat_cnt statistics port.
// -----------------------------------------------------------------------------
module exp_row_align #(
  parameter int ROW_LEN  = 16,
  parameter int FP_EXP_W = 8,
  parameter int SHIFT_W  = 5
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [FP_EXP_W*ROW_LEN-1:0] in_exp,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [FP_EXP_W-1:0]         out_max_exp,
  output logic [SHIFT_W*ROW_LEN-1:0]  out_shift,
  output logic [ROW_LEN-1:0]          out_zero_mask,
  output logic                        out_last,
  output logic [7:0]                  out_row_idx
`ifdef EXP_ALIGN_STATS_EN
  ,
  output logic [15:0]                 sat_cnt
`endif
);

  // Difference width: wide enough for both exponent and shift ranges, plus a
  // spare bit, so the saturation compare never truncates.
  localparam int DW = ((FP_EXP_W > SHIFT_W) ? FP_EXP_W : SHIFT_W) + 1;
  localparam logic [SHIFT_W-1:0] SHIFT_MAX = {SHIFT_W{1'b1}};

  // Width of a per-row count of saturated elements (0..ROW_LEN).
  localparam int CW = $clog2(ROW_LEN + 1);

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Distance from the row maximum; never negative because mx >= e.
  function automatic logic [DW-1:0] exp_diff(input logic [FP_EXP_W-1:0] mx,
                                             input logic [FP_EXP_W-1:0] e);
    return DW'(mx) - DW'(e);
  endfunction

  // True when a non-zero element's shift would exceed the cap.
  function automatic logic is_sat(input logic [FP_EXP_W-1:0] mx,
                                  input logic [FP_EXP_W-1:0] e);
    logic res;
    if (e == {FP_EXP_W{1'b0}}) begin
      res = 1'b0;
    end else begin
      res = (exp_diff(mx, e) > DW'(SHIFT_MAX));
    end
    return res;
  endfunction

  // A zero exponent is pushed fully out of range; a non-zero exponent is
  // shifted by its distance to the maximum, clamped to SHIFT_MAX.
  function automatic logic [SHIFT_W-1:0] calc_shift(input logic [FP_EXP_W-1:0] mx,
                                                    input logic [FP_EXP_W-1:0] e);
    logic [SHIFT_W-1:0] res;
    if (e == {FP_EXP_W{1'b0}}) begin
      res = SHIFT_MAX;
    end else if (is_sat(mx, e)) begin
      res = SHIFT_MAX;
    end else begin
      res = SHIFT_W'(exp_diff(mx, e));
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage registers and handshake control
  // ---------------------------------------------------------------------------
  logic                        s1_valid_r;
  logic [FP_EXP_W*ROW_LEN-1:0] s1_exp_r;
  logic                        s1_last_r;
  logic [FP_EXP_W-1:0]         s1_max_r;

  // Index that the next row entering stage 2 will carry.
  logic [7:0]                  row_idx_next_r;

  logic                        s2_load_ok_s;
  logic                        s1_adv_s;
  logic [FP_EXP_W-1:0]         row_max_s;
  logic [SHIFT_W*ROW_LEN-1:0]  shift_s;
  logic [ROW_LEN-1:0]          zmask_s;

  // Stage 2 can take a row when it is empty or its row leaves this cycle.
  // Stage 1 can then pass its row on, and so it can accept a new input row.
  assign s2_load_ok_s = !out_valid || out_ready;
  assign s1_adv_s     = s1_valid_r && s2_load_ok_s;
  assign in_ready     = !s1_valid_r || s1_adv_s;

  // Row maximum of the incoming exponents. Zero elements cannot raise the
  // maximum, so an all-zero row yields 0.
  always_comb begin
    row_max_s = {FP_EXP_W{1'b0}};
    for (int k = 0; k < ROW_LEN; k++) begin
      if (in_exp[(k+1)*FP_EXP_W-1 -: FP_EXP_W] > row_max_s) begin
        row_max_s = in_exp[(k+1)*FP_EXP_W-1 -: FP_EXP_W];
      end else begin
        row_max_s = row_max_s;
      end
    end
  end

  // Per-element shift amounts and zero mask for the row held in stage 1.
  always_comb begin
    shift_s = {(SHIFT_W*ROW_LEN){1'b0}};
    zmask_s = {ROW_LEN{1'b0}};
    for (int k = 0; k < ROW_LEN; k++) begin
      shift_s[(k+1)*SHIFT_W-1 -: SHIFT_W] =
        calc_shift(s1_max_r, s1_exp_r[(k+1)*FP_EXP_W-1 -: FP_EXP_W]);
      zmask_s[k] = (s1_exp_r[(k+1)*FP_EXP_W-1 -: FP_EXP_W] == {FP_EXP_W{1'b0}});
    end
  end

  // Stage 1: capture an accepted input row together with its maximum.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid_r <= 1'b0;
      s1_exp_r   <= {(FP_EXP_W*ROW_LEN){1'b0}};
      s1_last_r  <= 1'b0;
      s1_max_r   <= {FP_EXP_W{1'b0}};
    end else if (in_ready) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_exp_r  <= in_exp;
        s1_last_r <= in_last;
        s1_max_r  <= row_max_s;
      end
    end
  end

`ifdef EXP_ALIGN_STATS_EN
  logic [CW-1:0] sat_row_s;
  logic [CW-1:0] s2_sat_r;
  logic [16:0]   sat_sum_s;

  // Number of saturated non-zero elements in the stage-1 row.
  always_comb begin
    sat_row_s = {CW{1'b0}};
    for (int k = 0; k < ROW_LEN; k++) begin
      if (is_sat(s1_max_r, s1_exp_r[(k+1)*FP_EXP_W-1 -: FP_EXP_W])) begin
        sat_row_s = sat_row_s + CW'(1);
      end else begin
        sat_row_s = sat_row_s;
      end
    end
  end

  // Running total plus the departing row's count. The extra bit detects
  // overflow so the counter can stick at 0xFFFF.
  assign sat_sum_s = {1'b0, sat_cnt} + 17'(s2_sat_r);

  // Carry the per-row saturation count alongside the row in stage 2.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s2_sat_r <= {CW{1'b0}};
    end else if (s2_load_ok_s && s1_valid_r) begin
      s2_sat_r <= sat_row_s;
    end
  end

  // Add each departing row's count, saturating at 0xFFFF.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sat_cnt <= 16'h0000;
    end else if (out_valid && out_ready) begin
      if (sat_sum_s[16]) begin
        sat_cnt <= 16'hFFFF;
      end else begin
        sat_cnt <= sat_sum_s[15:0];
      end
    end
  end
`endif

  // Stage 2: the output registers. A row is loaded only when the slot frees,
  // so held outputs stay stable while downstream stalls. The row index is
  // fixed when a row enters stage 2. Rows leave in order, so that index equals
  // the number of outputs since the last tile end.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid      <= 1'b0;
      out_max_exp    <= {FP_EXP_W{1'b0}};
      out_shift      <= {(SHIFT_W*ROW_LEN){1'b0}};
      out_zero_mask  <= {ROW_LEN{1'b0}};
      out_last       <= 1'b0;
      out_row_idx    <= 8'd0;
      row_idx_next_r <= 8'd0;
    end else if (s2_load_ok_s) begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        out_max_exp   <= s1_max_r;
        out_shift     <= shift_s;
        out_zero_mask <= zmask_s;
        out_last      <= s1_last_r;
        out_row_idx   <= row_idx_next_r;
        if (s1_last_r) begin
          row_idx_next_r <= 8'd0;
        end else begin
          row_idx_next_r <= row_idx_next_r + 8'd1;
        end
      end
    end
  end

endmodule
